// File: rtl/twos_pkg.sv
// Shared definitions for the bit-serial two's-complement to sign-magnitude
// decoder: FSM state encoding and the default data width.
package twos_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/twos_to_signmag_serial_cell.sv
// serial_twos_cell: one bit-slice of the copy-up-to-first-1-then-invert rule.
// Holds the "a 1 has already gone past" flag and picks copy or invert for the
// bit currently being presented.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr       start of a new word: forget any 1 seen so far
//   en        a bit is being consumed this cycle
//   sign      sign of the word being converted (invert only for negatives)
//   b_in      current two's-complement bit, LSB first
//   o         magnitude bit for the current position
module serial_twos_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sign,
  input  logic b_in,
  output logic o
);

  logic seen_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_one <= 1'b0;
    end else if (clr) begin
      seen_one <= 1'b0;
    end else if (en) begin
      seen_one <= seen_one | b_in;
    end
  end

  // Bits up to and including the first 1 pass through unchanged; every bit
  // after it is inverted, but only when the word is negative.
  assign o = (sign & seen_one) ? ~b_in : b_in;

endmodule

// File: rtl/twos_to_signmag_serial.sv
// twos_to_signmag_serial: converts a WIDTH-bit two's-complement word into a
// sign bit plus unsigned magnitude, one bit per clock, LSB first.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid is held until then, ready never depends on valid.
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   in_valid, in_ready   input handshake (in_ready high only in IDLE)
//   in_data              two's-complement operand
//   out_valid, out_ready output handshake (out_valid high only in DONE)
//   out_sign, out_mag    sign and |in_data|; hold their value until the
//                        next conversion overwrites them
//   dbg_state            current FSM state, for observation only
module twos_to_signmag_serial
  import twos_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] mag;
  logic             sign_q;
  logic             accept;
  logic             conv_en;
  logic             cell_o;

  // in_ready is decoded from state, so this is the plain handshake.
  assign accept  = (state == ST_IDLE) & in_valid;
  assign conv_en = (state == ST_CONV);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)        state_nxt = ST_CONV;
      ST_CONV: if (cnt == CNT_LAST) state_nxt = ST_DONE;
      ST_DONE: if (out_ready)       state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // Output decode (state only)
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  serial_twos_cell u_cell (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (conv_en),
    .sign (sign_q),
    .b_in (shift_reg[0]),
    .o    (cell_o)
  );

  // Datapath: operand shifts out LSB first, magnitude fills from the top so
  // that after WIDTH shifts the first bit produced sits at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      mag       <= '0;
      sign_q    <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      shift_reg <= in_data;
      sign_q    <= in_data[WIDTH-1];
      cnt       <= '0;
    end else if (conv_en) begin
      shift_reg <= shift_reg >> 1;
      mag       <= {cell_o, mag[WIDTH-1:1]};
      cnt       <= cnt + 1'b1;
    end
  end

  assign out_sign  = sign_q;
  assign out_mag   = mag;
  assign dbg_state = state;

endmodule
